// File: rtl/dmem_pkg.sv
// dmem_pkg: shared defaults and word type for the two-write two-read data memory
package dmem_pkg;
  localparam int DEPTH_DEF = 64;
  localparam int AW_DEF = 6;
  typedef logic [31:0] word_t;
endpackage

// File: rtl/dmem_wr_arb.sv
// dmem_wr_arb: per-word write enable and data, port 2 wins when both ports hit one word
module dmem_wr_arb
  import dmem_pkg::*;
#(
  parameter int DEPTH = DEPTH_DEF,
  parameter int AW    = AW_DEF
) (
  input  logic                 i_we1,
  input  logic [AW-1:0]        i_idx1,
  input  word_t                i_wd1,
  input  logic                 i_we2,
  input  logic [AW-1:0]        i_idx2,
  input  word_t                i_wd2,
  output logic [DEPTH-1:0]     o_we,
  output word_t [DEPTH-1:0]    o_wd
);
  for (genvar g = 0; g < DEPTH; g++) begin : g_word
    logic w_hit1;
    logic w_hit2;
    assign w_hit1  = i_we1 && (i_idx1 == AW'(g));
    assign w_hit2  = i_we2 && (i_idx2 == AW'(g));
    assign o_we[g] = w_hit1 || w_hit2;
    assign o_wd[g] = w_hit2 ? i_wd2 : i_wd1;
  end
endmodule

// File: rtl/dmem_2w2r.sv
// dmem_2w2r: word-addressed RAM with two write ports, two combinational read ports, async clear
module dmem_2w2r
  import dmem_pkg::*;
#(
  parameter int DEPTH = DEPTH_DEF,
  parameter int AW    = AW_DEF
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        we1,
  input  logic [31:0] a1,
  input  logic [31:0] wd1,
  output logic [31:0] rd1,
  input  logic        we2,
  input  logic [31:0] a2,
  input  logic [31:0] wd2,
  output logic [31:0] rd2
);
  word_t              RAM [DEPTH];
  logic [AW-1:0]      w_idx1;
  logic [AW-1:0]      w_idx2;
  logic [DEPTH-1:0]   w_we;
  word_t [DEPTH-1:0]  w_wd;
  logic               w_unused;
  // byte offset and bits above the array are dropped, so addresses wrap
  assign w_idx1   = a1[AW+1:2];
  assign w_idx2   = a2[AW+1:2];
  assign w_unused = ^{a1[31:AW+2], a1[1:0], a2[31:AW+2], a2[1:0]};
  dmem_wr_arb #(.DEPTH(DEPTH), .AW(AW)) u_arb (
    .i_we1 (we1),
    .i_idx1(w_idx1),
    .i_wd1 (wd1),
    .i_we2 (we2),
    .i_idx2(w_idx2),
    .i_wd2 (wd2),
    .o_we  (w_we),
    .o_wd  (w_wd)
  );
  always_ff @(posedge clk or negedge reset)
    if (!reset)
      for (int i = 0; i < DEPTH; i++) RAM[i] <= '0;
    else
      for (int i = 0; i < DEPTH; i++) if (w_we[i]) RAM[i] <= w_wd[i];
  assign rd1 = RAM[w_idx1];
  assign rd2 = RAM[w_idx2];
endmodule

// File: tb/tb_dmem_2w2r.sv
// tb_dmem_2w2r: directed vectors against a word-array model of the memory
module tb_dmem_2w2r;
  logic        clk = 0;
  logic        reset = 1;
  logic        we1 = 0, we2 = 0;
  logic [31:0] a1 = 0, a2 = 0, wd1 = 0, wd2 = 0;
  logic [31:0] rd1, rd2;
  logic [31:0] m [64];
  logic [31:0] pre1, pre2;
  logic        chk_en = 0;
  int          n_pass = 0, n_total = 0;

  dmem_2w2r dut (
    .clk(clk), .reset(reset),
    .we1(we1), .a1(a1), .wd1(wd1), .rd1(rd1),
    .we2(we2), .a2(a2), .wd2(wd2), .rd2(rd2)
  );

  always #5 clk = ~clk;

  function automatic int ix(input logic [31:0] a);
    return int'((a >> 2) % 64);
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", name, act, exp);
  endtask

  always @(negedge clk)
    if (chk_en) begin
      check("rd1_model", rd1, m[ix(a1)]);
      check("rd2_model", rd2, m[ix(a2)]);
    end

  task automatic cyc(input logic w1, input logic [31:0] ad1, input logic [31:0] d1,
                     input logic w2, input logic [31:0] ad2, input logic [31:0] d2);
    we1 = w1; a1 = ad1; wd1 = d1;
    we2 = w2; a2 = ad2; wd2 = d2;
    @(negedge clk);
    #1;
    pre1 = rd1;
    pre2 = rd2;
    @(posedge clk);
    if (reset) begin
      if (w1) m[ix(ad1)] = d1;
      if (w2) m[ix(ad2)] = d2;
    end
    #1;
    we1 = 0; we2 = 0;
  endtask

  initial begin
    for (int i = 0; i < 64; i++) m[i] = '0;
    #2 reset = 0;
    chk_en = 1;
    a1 = 32'h14;
    #1;
    check("reset_rd1", rd1, 32'h0);
    check("reset_ram5", dut.RAM[5], 32'h0);
    @(posedge clk);
    #1 reset = 1;
    cyc(1, 32'h08, 32'hDEADBEEF, 0, 32'h0, 32'h0);
    check("rdw_old", pre1, 32'h0);
    cyc(0, 32'h0, 32'h0, 0, 32'h08, 32'h0);
    check("rd2_after_wr", pre2, 32'hDEADBEEF);
    cyc(1, 32'h10, 32'h11111111, 1, 32'h13, 32'h22222222);
    check("collide_p2_wins", dut.RAM[4], 32'h22222222);
    cyc(1, 32'h00, 32'hA, 1, 32'h04, 32'hB);
    check("dual_ram0", dut.RAM[0], 32'hA);
    check("dual_ram1", dut.RAM[1], 32'hB);
    cyc(1, 32'h100, 32'h5, 0, 32'h0, 32'h0);
    check("wrap_ram0", dut.RAM[0], 32'h5);
    cyc(0, 32'h0B, 32'h0, 0, 32'h10, 32'h0);
    check("lowbits_ignored", pre1, 32'hDEADBEEF);
    check("hold_ram4", pre2, 32'h22222222);
    cyc(1, 32'hFC, 32'h12345678, 1, 32'h1F8, 32'h9ABCDEF0);
    check("top_word", dut.RAM[63], 32'h12345678);
    check("wrap_p2", dut.RAM[62], 32'h9ABCDEF0);
    cyc(0, 32'h0, 32'h0, 1, 32'h04, 32'hCAFEF00D);
    check("p2_only", dut.RAM[1], 32'hCAFEF00D);
    check("p2_only_keep0", dut.RAM[0], 32'h5);
    dut.RAM[3] = 32'h7;
    m[3] = 32'h7;
    a1 = 32'h0C;
    #1;
    check("preload_rd1", rd1, 32'h7);
    reset = 0;
    for (int i = 0; i < 64; i++) m[i] = '0;
    #1;
    check("async_clr_ram3", dut.RAM[3], 32'h0);
    check("async_clr_rd1", rd1, 32'h0);
    cyc(1, 32'h0C, 32'h99, 1, 32'h20, 32'h77);
    check("no_wr_in_reset", dut.RAM[3], 32'h0);
    check("no_wr2_in_reset", dut.RAM[8], 32'h0);
    reset = 1;
    cyc(1, 32'h0C, 32'h42, 0, 32'h0, 32'h0);
    check("wr_after_reset", dut.RAM[3], 32'h42);
    cyc(0, 32'h0C, 32'h0, 0, 32'h3F0, 32'h0);
    check("final_rd1", pre1, 32'h42);
    check("final_rd2_cleared", pre2, 32'h0);
    chk_en = 0;
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end
endmodule
